// File: rtl/score_board.sv
`default_nettype none
// ============================================================================
// Module   : score_board
// Purpose  : Per-frame BCD score keeper with a 4-digit seven-segment overlay
//            layer in the same rgb/alpha format as the sprite blocks.
// Revision : 1.0  initial release
// ============================================================================
module score_board #(
    parameter int                         H_DISP_LEN      = 11,
    parameter int                         V_DISP_LEN      = 10,
    parameter int                         COLOR_RGB_DEPTH = 12,
    parameter int                         X0              = 16,
    parameter int                         Y0              = 16,
    parameter logic [COLOR_RGB_DEPTH-1:0] FG_COLOR        = 12'hFF0
) (
    input  logic                       clk_vga,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic                       v_sync_i,
    input  logic                       gamestart_i,
    input  logic                       crash_enemy_bullet_i,
    input  logic [H_DISP_LEN-1:0]      req_x_addr_i,
    input  logic [V_DISP_LEN-1:0]      req_y_addr_i,
    output logic [COLOR_RGB_DEPTH-1:0] vga_rgb_o,
    output logic                       vga_alpha_o,
    output logic [15:0]                score_o
);

    localparam logic [H_DISP_LEN-1:0] c_X0      = H_DISP_LEN'(X0);
    localparam logic [V_DISP_LEN-1:0] c_Y0      = V_DISP_LEN'(Y0);
    localparam logic [H_DISP_LEN-1:0] c_FIELD_W = H_DISP_LEN'(64);
    localparam logic [V_DISP_LEN-1:0] c_FIELD_H = V_DISP_LEN'(32);
    localparam logic [15:0]           c_SCORE_MAX = 16'h9999;

    logic        r_vs_d;
    logic        r_hit_pend;
    logic [15:0] r_score;
    logic [COLOR_RGB_DEPTH-1:0] r_rgb;
    logic        r_alpha;

    logic        w_frame_edge;
    logic [15:0] w_score_inc;
    logic        w_cy;

    assign w_frame_edge = r_vs_d & ~v_sync_i;

    // ------------------------------------------------------------------
    // Frame tracking and hit latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= v_sync_i;
        end
    end

    // A crash coinciding with the frame edge wins, so it counts in the new frame.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_hit_pend <= 1'b0;
        end else if (gamestart_i) begin
            r_hit_pend <= 1'b0;
        end else if (crash_enemy_bullet_i) begin
            r_hit_pend <= 1'b1;
        end else if (w_frame_edge) begin
            r_hit_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // BCD increment with ripple carry across digits
    // ------------------------------------------------------------------
    always_comb begin
        w_score_inc = r_score;
        w_cy        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_cy) begin
                if (r_score[4*i +: 4] == 4'd9) begin
                    w_score_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
                    w_cy                  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_score <= 16'h0000;
        end else if (gamestart_i) begin
            r_score <= 16'h0000;
        end else if (w_frame_edge && r_hit_pend && (r_score != c_SCORE_MAX)) begin
            r_score <= w_score_inc;
        end
    end

    assign score_o = r_score;

    // ------------------------------------------------------------------
    // Field geometry; the >= guard stops an underflowed offset aliasing in
    // ------------------------------------------------------------------
    logic [H_DISP_LEN-1:0] w_dx;
    logic [V_DISP_LEN-1:0] w_dy;
    logic                  w_in_field;
    logic [1:0]            w_cell;
    logic [3:0]            w_lx;
    logic [4:0]            w_ly;

    assign w_dx       = req_x_addr_i - c_X0;
    assign w_dy       = req_y_addr_i - c_Y0;
    assign w_in_field = (req_x_addr_i >= c_X0) && (w_dx < c_FIELD_W) &&
                        (req_y_addr_i >= c_Y0) && (w_dy < c_FIELD_H);
    assign w_cell     = w_dx[5:4];
    assign w_lx       = w_dx[3:0];
    assign w_ly       = w_dy[4:0];

    // ------------------------------------------------------------------
    // Digit select and leading-zero blanking (cell 0 is thousands)
    // ------------------------------------------------------------------
    logic [3:0] w_digit;
    logic       w_blank;

    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (w_cell)
            2'd0: begin
                w_digit = r_score[15:12];
                w_blank = (r_score[15:12] == 4'd0);
            end
            2'd1: begin
                w_digit = r_score[11:8];
                w_blank = (r_score[15:8] == 8'd0);
            end
            2'd2: begin
                w_digit = r_score[7:4];
                w_blank = (r_score[15:4] == 12'd0);
            end
            default: begin
                w_digit = r_score[3:0];
                w_blank = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Segment set per digit, ordered {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------
    logic [6:0] w_segs;

    always_comb begin
        w_segs = 7'b0000000;
        case (w_digit)
            4'd0:    w_segs = 7'b1111110;
            4'd1:    w_segs = 7'b0110000;
            4'd2:    w_segs = 7'b1101101;
            4'd3:    w_segs = 7'b1111001;
            4'd4:    w_segs = 7'b0110011;
            4'd5:    w_segs = 7'b1011011;
            4'd6:    w_segs = 7'b1011111;
            4'd7:    w_segs = 7'b1110000;
            4'd8:    w_segs = 7'b1111111;
            4'd9:    w_segs = 7'b1111011;
            default: w_segs = 7'b0000000;
        endcase
    end

    // Pixel-to-segment regions inside a 16x32 cell; columns 12-15 are the gap
    logic       w_col_ok;
    logic [6:0] w_region;
    logic       w_seg_hit;

    assign w_col_ok    = (w_lx <= 4'd11);
    assign w_region[6] = w_col_ok && (w_ly <= 5'd3);
    assign w_region[5] = w_col_ok && (w_lx >= 4'd8) && (w_ly <= 5'd17);
    assign w_region[4] = w_col_ok && (w_lx >= 4'd8) && (w_ly >= 5'd14);
    assign w_region[3] = w_col_ok && (w_ly >= 5'd28);
    assign w_region[2] = (w_lx <= 4'd3) && (w_ly >= 5'd14);
    assign w_region[1] = (w_lx <= 4'd3) && (w_ly <= 5'd17);
    assign w_region[0] = w_col_ok && (w_ly >= 5'd14) && (w_ly <= 5'd17);
    assign w_seg_hit   = |(w_region & w_segs);

    // ------------------------------------------------------------------
    // Registered pixel output, one cycle after the request
    // ------------------------------------------------------------------
    logic w_lit;

    assign w_lit = en_i & w_in_field & ~w_blank & w_seg_hit;

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_alpha <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_alpha <= w_lit;
            r_rgb   <= w_lit ? FG_COLOR : '0;
        end
    end

    assign vga_alpha_o = r_alpha;
    assign vga_rgb_o   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_score_board.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_board
// Purpose  : Directed self-checking bench for score_board.
// Revision : 1.0  initial release
// ============================================================================
module tb_score_board;

    localparam int X0 = 16;
    localparam int Y0 = 16;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        en_i;
    logic        v_sync_i;
    logic        gamestart_i;
    logic        crash_enemy_bullet_i;
    logic [10:0] req_x_addr_i;
    logic [9:0]  req_y_addr_i;
    logic [11:0] vga_rgb_o;
    logic        vga_alpha_o;
    logic [15:0] score_o;

    int checks = 0;
    int errors = 0;

    score_board #(
        .H_DISP_LEN      (11),
        .V_DISP_LEN      (10),
        .COLOR_RGB_DEPTH (12),
        .X0              (X0),
        .Y0              (Y0),
        .FG_COLOR        (12'hFF0)
    ) dut (
        .clk_vga              (clk_vga),
        .rst                  (rst),
        .en_i                 (en_i),
        .v_sync_i             (v_sync_i),
        .gamestart_i          (gamestart_i),
        .crash_enemy_bullet_i (crash_enemy_bullet_i),
        .req_x_addr_i         (req_x_addr_i),
        .req_y_addr_i         (req_y_addr_i),
        .vga_rgb_o            (vga_rgb_o),
        .vga_alpha_o          (vga_alpha_o),
        .score_o              (score_o)
    );

    always #5 clk_vga = ~clk_vga;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame: optional one-cycle crash, then a v_sync falling edge
    task automatic frame(input logic hit);
        crash_enemy_bullet_i = hit;
        v_sync_i             = 1'b1;
        tick();
        crash_enemy_bullet_i = 1'b0;
        v_sync_i             = 1'b0;
        tick();
        v_sync_i             = 1'b1;
        tick();
    endtask

    task automatic pixel(input string tag, input int x, input int y, input logic en,
                         input logic exp_alpha);
        req_x_addr_i = 11'(x);
        req_y_addr_i = 10'(y);
        en_i         = en;
        tick();
        check({tag, "_alpha"}, {15'd0, vga_alpha_o}, {15'd0, exp_alpha});
        check({tag, "_rgb"}, {4'd0, vga_rgb_o}, exp_alpha ? 16'h0FF0 : 16'h0000);
    endtask

    initial begin
        rst                  = 1'b1;
        en_i                 = 1'b0;
        v_sync_i             = 1'b1;
        gamestart_i          = 1'b0;
        crash_enemy_bullet_i = 1'b1;
        req_x_addr_i         = 11'(X0 + 48);
        req_y_addr_i         = 10'(Y0);

        // Reset held 3 cycles with crash asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_score", score_o, 16'h0000);
            check("reset_alpha", {15'd0, vga_alpha_o}, 16'h0000);
        end
        rst                  = 1'b0;
        crash_enemy_bullet_i = 1'b0;
        tick();
        check("post_reset_score", score_o, 16'h0000);
        check("post_reset_alpha", {15'd0, vga_alpha_o}, 16'h0000);

        // Multi-cycle hit inside one frame counts once
        crash_enemy_bullet_i = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        crash_enemy_bullet_i = 1'b0;
        v_sync_i             = 1'b0;
        tick();
        check("multi_hit", score_o, 16'h0001);
        v_sync_i = 1'b1;
        tick();
        frame(1'b0);
        check("idle_frame", score_o, 16'h0001);

        // Carry 0099 -> 0100
        for (int i = 0; i < 98; i++) frame(1'b1);
        check("preload_99", score_o, 16'h0099);
        frame(1'b1);
        check("carry_100", score_o, 16'h0100);

        // Saturation at 9999
        for (int i = 0; i < 9899; i++) frame(1'b1);
        check("preload_9999", score_o, 16'h9999);
        frame(1'b1);
        check("saturate", score_o, 16'h9999);

        gamestart_i = 1'b1;
        tick();
        gamestart_i = 1'b0;
        check("gamestart_clear", score_o, 16'h0000);

        // Render with score 0042
        for (int i = 0; i < 42; i++) frame(1'b1);
        check("preload_42", score_o, 16'h0042);
        pixel("seg_f_digit4", X0 + 33, Y0 + 1, 1'b1, 1'b1);
        pixel("lead_zero",    X0 + 1,  Y0 + 1, 1'b1, 1'b0);
        pixel("gap_col",      X0 + 45, Y0 + 1, 1'b1, 1'b0);
        pixel("en_low",       X0 + 33, Y0 + 1, 1'b0, 1'b0);
        pixel("digit2_no_c",  X0 + 57, Y0 + 20, 1'b1, 1'b0);
        pixel("digit2_e",     X0 + 49, Y0 + 20, 1'b1, 1'b1);
        pixel("digit4_no_a",  X0 + 32, Y0 + 1 + 0 * 1 + 0, 1'b1, 1'b1);
        pixel("digit4_mid_a", X0 + 37, Y0 + 1, 1'b1, 1'b0);
        en_i = 1'b0;

        // gamestart in the frame_edge cycle with hit pending, score 0005
        gamestart_i = 1'b1;
        tick();
        gamestart_i = 1'b0;
        for (int i = 0; i < 5; i++) frame(1'b1);
        check("preload_5", score_o, 16'h0005);
        crash_enemy_bullet_i = 1'b1;
        tick();
        crash_enemy_bullet_i = 1'b0;
        v_sync_i             = 1'b0;
        gamestart_i          = 1'b1;
        tick();
        gamestart_i = 1'b0;
        v_sync_i    = 1'b1;
        check("gamestart_at_edge", score_o, 16'h0000);
        tick();
        frame(1'b0);
        check("hit_pend_cleared", score_o, 16'h0000);

        // Boundary addresses with score 0000
        pixel("left_of_field", X0 - 1,  Y0,      1'b1, 1'b0);
        pixel("below_field",   X0 + 48, Y0 + 32, 1'b1, 1'b0);
        pixel("units_zero_a",  X0 + 48, Y0,      1'b1, 1'b1);
        pixel("above_field",   X0 + 48, Y0 - 1,  1'b1, 1'b0);
        en_i = 1'b0;

        // Crash only in the frame_edge cycle belongs to the next frame
        v_sync_i = 1'b1;
        tick();
        crash_enemy_bullet_i = 1'b1;
        v_sync_i             = 1'b0;
        tick();
        crash_enemy_bullet_i = 1'b0;
        check("edge_crash_now", score_o, 16'h0000);
        v_sync_i = 1'b1;
        tick();
        v_sync_i = 1'b0;
        tick();
        check("edge_crash_next", score_o, 16'h0001);
        v_sync_i = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
